// File: rtl/abs_diff_acc_if.sv
// Handshake bundle for abs_diff_acc: operand input, per-pair diff output
// and held frame-sum output.
interface abs_diff_acc_if #(
  parameter int W     = 4,
  parameter int N     = 16,
  parameter int ACC_W = W + $clog2(N) + (N == 1)
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             diff_valid;
  logic [W-1:0]     diff;
  logic             sad_valid;
  logic             sad_ready;
  logic [ACC_W-1:0] sad;

  modport master (
    output in_valid, a, b, sad_ready,
    input  in_ready, diff_valid, diff, sad_valid, sad
  );

  modport slave (
    input  in_valid, a, b, sad_ready,
    output in_ready, diff_valid, diff, sad_valid, sad
  );
endinterface

// File: rtl/abs_diff_acc.sv
// Sum of absolute differences over N accepted operand pairs, with a per-pair
// registered |a-b|. Define ABS_DIFF_SAT_EN for a saturating accumulator (wraps otherwise).
module abs_diff_acc #(
  parameter int W     = 4,
  parameter int N     = 16,
  parameter int ACC_W = W + $clog2(N) + (N == 1)
) (
  input logic          clk,
  input logic          rst,
  abs_diff_acc_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     ad;
  logic [W-1:0]     diff_q;
  logic             diff_valid_q;
  logic             accept;
  logic [ACC_W-1:0] acc_add;

  always_comb begin
    ad = (bus.a >= bus.b) ? (bus.a - bus.b) : (bus.b - bus.a);
  end

  assign bus.in_ready   = (state != DONE);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.diff       = diff_q;
  assign bus.diff_valid = diff_valid_q;
  assign bus.sad_valid  = (state == DONE);
  assign bus.sad        = acc;

`ifdef ABS_DIFF_SAT_EN
  // One extra carry bit detects overflow; once pinned at all-ones, later
  // non-negative adds keep it there for the rest of the frame.
  logic [ACC_W:0] sum_ext;
  always_comb begin
    sum_ext = {1'b0, acc} + (ACC_W + 1)'(ad);
    acc_add = sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
  end
`else
  always_comb begin
    acc_add = acc + ACC_W'(ad);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      cnt          <= '0;
      diff_q       <= '0;
      diff_valid_q <= 1'b0;
    end else begin
      diff_valid_q <= accept;
      if (accept) diff_q <= ad;

      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= ACC_W'(ad);
            cnt   <= CNT_W'(1);
            state <= (N == 1) ? DONE : ACC;
          end
        end
        ACC: begin
          if (accept) begin
            acc <= acc_add;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(N - 1)) state <= DONE;
          end
        end
        DONE: begin
          if (bus.sad_ready) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_abs_diff_acc.sv
// Self-checking bench: two abs_diff_acc instances (default ACC_W and ACC_W=5)
// driven in lockstep and compared with a frame-level reference model.
module tb_abs_diff_acc;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int AW_A = 6;
  localparam int AW_B = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         sad_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;

  int checks = 0;
  int errors = 0;

  abs_diff_acc_if #(.W(W), .N(N), .ACC_W(AW_A)) ifa ();
  abs_diff_acc_if #(.W(W), .N(N), .ACC_W(AW_B)) ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.a         = a;
  assign ifa.b         = b;
  assign ifa.sad_ready = sad_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.a         = a;
  assign ifb.b         = b;
  assign ifb.sad_ready = sad_ready;

  abs_diff_acc #(.W(W), .N(N), .ACC_W(AW_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  abs_diff_acc #(.W(W), .N(N), .ACC_W(AW_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  // Reference model: true (unbounded) frame sum plus frame bookkeeping.
  bit m_known = 1'b0;
  bit m_done  = 1'b0;
  bit m_dv    = 1'b0;
  int m_cnt   = 0;
  int m_sum   = 0;
  int m_diff  = 0;

  function automatic int exp_sad(int aw);
    int maxv = (1 << aw) - 1;
`ifdef ABS_DIFF_SAT_EN
    return (m_sum > maxv) ? maxv : m_sum;
`else
    return m_sum & maxv;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are set at posedge+1; outputs are sampled on the negedge, then the
  // model advances across the following posedge.
  task automatic cycle();
    int d;
    @(negedge clk);
    if (m_known) begin
      chk("in_ready_a", int'(ifa.in_ready), int'(!m_done));
      chk("in_ready_b", int'(ifb.in_ready), int'(!m_done));
      chk("diff_valid_a", int'(ifa.diff_valid), int'(m_dv));
      chk("diff_valid_b", int'(ifb.diff_valid), int'(m_dv));
      chk("diff_a", int'(ifa.diff), m_diff);
      chk("diff_b", int'(ifb.diff), m_diff);
      chk("sad_valid_a", int'(ifa.sad_valid), int'(m_done));
      chk("sad_valid_b", int'(ifb.sad_valid), int'(m_done));
      if (m_done) begin
        chk("sad_a", int'(ifa.sad), exp_sad(AW_A));
        chk("sad_b", int'(ifb.sad), exp_sad(AW_B));
      end
    end
    if (rst) begin
      m_known = 1'b1;
      m_done = 1'b0; m_dv = 1'b0; m_cnt = 0; m_sum = 0; m_diff = 0;
    end else begin
      m_dv = 1'b0;
      if (!m_done && in_valid) begin
        d = (int'(a) > int'(b)) ? int'(a) - int'(b) : int'(b) - int'(a);
        m_diff = d;
        m_dv = 1'b1;
        m_sum += d;
        m_cnt++;
        if (m_cnt == N) m_done = 1'b1;
      end else if (m_done && sad_ready) begin
        m_done = 1'b0; m_cnt = 0; m_sum = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int aa, input int bb, input bit sr);
    in_valid  = v;
    a         = W'(aa);
    b         = W'(bb);
    sad_ready = sr;
    cycle();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) drive(1'b1, 5, 1, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  typedef struct {
    int a;
    int b;
    int diff;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{3, 9, 6};
    vecs[1] = '{9, 3, 6};
    vecs[2] = '{0, 15, 15};
    vecs[3] = '{15, 0, 15};
    vecs[4] = '{7, 7, 0};
    vecs[5] = '{2, 5, 3};
    vecs[6] = '{14, 1, 13};
    vecs[7] = '{8, 9, 1};

    rst = 1'b1; in_valid = 1'b0; sad_ready = 1'b0; a = '0; b = '0;

    // Reset held two cycles, with an offered pair that must be dropped.
    do_reset(2);
    chk("rst_diff", int'(ifa.diff), 0);
    chk("rst_diff_valid", int'(ifa.diff_valid), 0);
    chk("rst_sad_valid", int'(ifa.sad_valid), 0);
    chk("rst_sad", int'(ifa.sad), 0);
    chk("rst_in_ready", int'(ifa.in_ready), 1);

    // Single pairs: diff one cycle after accept, then held with diff_valid low.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, 1'b0);
      chk("vec_diff_valid", int'(ifa.diff_valid), 1);
      chk("vec_diff", int'(ifa.diff), vecs[i].diff);
      drive(1'b0, 0, 0, 1'b0);
      chk("vec_diff_hold_valid", int'(ifa.diff_valid), 0);
      chk("vec_diff_hold", int'(ifa.diff), vecs[i].diff);
      drive(1'b0, 0, 0, 1'b1);
    end

    // Back-to-back frame summing to 33, then held through a stalled consumer.
    do_reset(1);
    drive(1'b1, 0, 15, 1'b0);
    drive(1'b1, 15, 0, 1'b0);
    drive(1'b1, 7, 7, 1'b0);
    drive(1'b1, 2, 5, 1'b0);
    chk("frame_sad_valid", int'(ifa.sad_valid), 1);
    chk("frame_sad", int'(ifa.sad), 33);
    chk("frame_in_ready", int'(ifa.in_ready), 0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1, 14, 1'b0);
    chk("stall_sad", int'(ifa.sad), 33);
    chk("stall_no_diff", int'(ifa.diff_valid), 0);
    drive(1'b0, 0, 0, 1'b1);
    chk("release_in_ready", int'(ifa.in_ready), 1);
    chk("release_sad_valid", int'(ifa.sad_valid), 0);

    // Overflow on the narrow accumulator: true sum 60.
    do_reset(1);
    for (int i = 0; i < 4; i++) drive(1'b1, 0, 15, 1'b0);
`ifdef ABS_DIFF_SAT_EN
    chk("ovf_sad_b", int'(ifb.sad), 31);
`else
    chk("ovf_sad_b", int'(ifb.sad), 28);
`endif
    chk("ovf_sad_a", int'(ifa.sad), 60);
    drive(1'b0, 0, 0, 1'b1);

    // Mid-frame reset discards the partial sum and the same-cycle pair.
    do_reset(1);
    drive(1'b1, 0, 15, 1'b0);
    drive(1'b1, 0, 15, 1'b0);
    rst = 1'b1;
    drive(1'b1, 0, 15, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) drive(1'b1, 1, 2, 1'b0);
    chk("midrst_sad_valid", int'(ifa.sad_valid), 1);
    chk("midrst_sad", int'(ifa.sad), 4);
    drive(1'b0, 0, 0, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive(($urandom_range(0, 9) < 7), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/abs_diff_acc.md
ABS_DIFF_ACC -- requirements
Module: abs_diff_acc

Interface
REQ-001 Parameter W, default 4, operand width in bits (W >= 2).
REQ-002 Parameter N, default 16, samples per frame (N >= 1).
REQ-003 Parameter ACC_W, default W+$clog2(N)+(N==1), accumulator/result width (ACC_W >= W).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operand pair a/b valid.
REQ-007 in_ready  output  1  block can accept a pair this cycle.
REQ-008 a  input  W  unsigned operand A.
REQ-009 b  input  W  unsigned operand B.
REQ-010 diff_valid  output  1  one-cycle pulse qualifying diff.
REQ-011 diff  output  W  registered |a-b| of last accepted pair.
REQ-012 sad_valid  output  1  frame sum available; held until taken.
REQ-013 sad_ready  input  1  consumer takes sad.
REQ-014 sad  output  ACC_W  sum of absolute differences over N accepted pairs.

Function
REQ-015 Accept event SHALL be in_valid && in_ready in the same cycle; no other condition consumes a/b.
REQ-016 diff SHALL be exact |a-b| in W bits, no approximation; registered with latency 1 cycle after accept; diff_valid high exactly that cycle.
REQ-017 diff SHALL hold its value when diff_valid is low.
REQ-018 FSM states SHALL be IDLE, ACC, DONE; reset state IDLE.
REQ-019 IDLE: in_ready=1; accept -> acc=|a-b|, cnt=1, next state ACC (DONE if N==1).
REQ-020 ACC: in_ready=1; accept -> acc=acc+|a-b|, cnt=cnt+1; accept when cnt==N-1 -> DONE; no accept -> hold.
REQ-021 DONE: in_ready=0, sad_valid=1, sad=acc stable; sad_ready=1 -> IDLE with acc and cnt cleared the same edge.
REQ-022 sad_valid SHALL first assert the cycle after the Nth accept (same cycle as its diff_valid).
REQ-023 in_valid during DONE SHALL be ignored; a/b may change freely.
REQ-024 Idle gaps between accepts within a frame SHALL not affect the sum.
REQ-025 Accumulator overflow behaviour SHALL follow REQ-030/REQ-031; with default ACC_W overflow is impossible.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE, acc=0, cnt=0, diff=0, diff_valid=0, sad_valid=0.
REQ-027 sad SHALL read 0 after reset; in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-028 rst mid-frame or in DONE SHALL discard the partial/unread sum; an accept in the same cycle as rst SHALL be dropped.

Configuration
REQ-029 Macro ABS_DIFF_SAT_EN selects accumulator overflow handling.
REQ-030 Defined: each add saturates at 2^ACC_W-1 and stays there for the rest of the frame.
REQ-031 Undefined: each add wraps modulo 2^ACC_W.

Verification
REQ-032 Reset: rst high 2 cycles -> diff=0, diff_valid=0, sad_valid=0, sad=0, in_ready=1 after release.
REQ-033 W=4,N=4: accept a=3,b=9 -> next cycle diff_valid=1, diff=6; following cycle diff_valid=0, diff=6.
REQ-034 W=4,N=4: pairs (0,15),(15,0),(7,7),(2,5) back-to-back -> sad_valid=1, sad=33 one cycle after 4th accept; in_ready=0.
REQ-035 Same frame, sad_ready low 5 cycles with in_valid=1 -> sad=33 held, no diff_valid, no accept; sad_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-036 W=4,N=4,ACC_W=5: four pairs (0,15) -> sad=31 with ABS_DIFF_SAT_EN, sad=28 without.
REQ-037 W=4,N=4: accept (0,15),(0,15), rst 1 cycle, then (1,2)x4 -> sad=4.
